// File: rtl/pcie_reset_sequencer.sv
// pcie_reset_sequencer: PERST#/PLL/link-training reset sequencer for the PCIe endpoint.
// Build option PCIE_SEQ_RETRAIN_EN: a link drop in UP retrains from WAIT_LINK
// with the core kept out of reset, instead of a full core-reset retry.
module pcie_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int PLL_SETTLE      = 256,
    parameter int LINK_TIMEOUT    = 2**20,
    parameter int MAX_RETRIES     = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pcie_rstn,
    input  logic          gt_pll_lock,
    input  logic          link_up,
    output logic          core_rst,
    output logic          user_rst,
    output logic          link_ready,
    output logic          seq_fail,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    seq_state
);
    localparam int CNT_A   = (DEBOUNCE_CYCLES > PLL_SETTLE) ? DEBOUNCE_CYCLES : PLL_SETTLE;
    localparam int CNT_MAX = (CNT_A > LINK_TIMEOUT) ? CNT_A : LINK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_SETTLE - 1);
    localparam logic [CW-1:0] LINK_LAST = CW'(LINK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_PLL  = 3'd1,
        RELEASE   = 3'd2,
        WAIT_LINK = 3'd3,
        RETRY     = 3'd4,
        UP        = 3'd5,
        FAIL      = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [RW-1:0]          retry_q, retry_d, retry_inc;
    logic [SYNC_STAGES-1:0] rstn_sync_q, rstn_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] link_sync_q, link_sync_d;
    logic                   core_rst_q, core_rst_d;
    logic                   user_rst_q, user_rst_d;
    logic                   link_ready_q, link_ready_d;
    logic                   seq_fail_q, seq_fail_d;
    logic                   rstn_s, lock_s, link_s;

    assign rstn_s = rstn_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];
    assign link_s = link_sync_q[SYNC_STAGES-1];

    // Synchroniser shifts and saturating increments for the shared counter and retry count
    always_comb begin
        rstn_sync_d = {rstn_sync_q[SYNC_STAGES-2:0], pcie_rstn};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], gt_pll_lock};
        link_sync_d = {link_sync_q[SYNC_STAGES-2:0], link_up};
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        retry_inc   = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);
    end

    // Next state, counter and retry accounting; a low PERST# overrides every other transition
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        retry_d = retry_q;
        case (state_q)
            HOLD: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_q == DEB_LAST) ? WAIT_PLL : HOLD;
                if (cnt_q == DEB_LAST) cnt_d = '0;
            end
            WAIT_PLL: begin
                cnt_d   = (lock_s && cnt_q != PLL_LAST) ? cnt_inc : '0;
                state_d = (lock_s && cnt_q == PLL_LAST) ? RELEASE : WAIT_PLL;
            end
            RELEASE: state_d = WAIT_LINK;
            WAIT_LINK: begin
                cnt_d = cnt_inc;
                if (link_s) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == LINK_LAST) begin
                    state_d = RETRY;
                    cnt_d   = '0;
                    retry_d = retry_inc;
                end
            end
            RETRY: begin
                cnt_d = cnt_inc;
                if (cnt_q == PLL_LAST) begin
                    state_d = (retry_q == RETRY_MAX) ? FAIL : WAIT_PLL;
                    cnt_d   = '0;
                end
            end
            UP: begin
                if (!link_s) begin
`ifdef PCIE_SEQ_RETRAIN_EN
                    state_d = WAIT_LINK;
`else
                    state_d = RETRY;
                    retry_d = retry_inc;
`endif
                end
            end
            FAIL:    state_d = FAIL;
            default: state_d = HOLD;
        endcase
        if (!rstn_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // Outputs decoded from the next state so they register in the same update as the state
    always_comb begin
        core_rst_d   = !(state_d == WAIT_LINK || state_d == UP);
        user_rst_d   = state_d != UP;
        link_ready_d = state_d == UP;
        seq_fail_d   = state_d == FAIL;
    end

    // Sequencer register bank: state, counters, synchronisers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            rstn_sync_q  <= '0;
            lock_sync_q  <= '0;
            link_sync_q  <= '0;
            core_rst_q   <= 1'b1;
            user_rst_q   <= 1'b1;
            link_ready_q <= 1'b0;
            seq_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            rstn_sync_q  <= rstn_sync_d;
            lock_sync_q  <= lock_sync_d;
            link_sync_q  <= link_sync_d;
            core_rst_q   <= core_rst_d;
            user_rst_q   <= user_rst_d;
            link_ready_q <= link_ready_d;
            seq_fail_q   <= seq_fail_d;
        end
    end

    assign core_rst   = core_rst_q;
    assign user_rst   = user_rst_q;
    assign link_ready = link_ready_q;
    assign seq_fail   = seq_fail_q;
    assign retry_cnt  = retry_q;
    assign seq_state  = state_q;
endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// tb_pcie_reset_sequencer: directed checks of the PCIe reset sequencer timing and priorities.
module tb_pcie_reset_sequencer;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int PLL_SETTLE      = 4;
    localparam int LINK_TIMEOUT    = 32;
    localparam int MAX_RETRIES     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pcie_rstn = 1'b0;
    logic       gt_pll_lock = 1'b1;
    logic       link_up = 1'b0;
    logic       core_rst, user_rst, link_ready, seq_fail;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;
    int         n_vec = 0;
    int         n_err = 0;

    pcie_reset_sequencer #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .PLL_SETTLE(PLL_SETTLE),
        .LINK_TIMEOUT(LINK_TIMEOUT),
        .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pcie_rstn(pcie_rstn),
        .gt_pll_lock(gt_pll_lock),
        .link_up(link_up),
        .core_rst(core_rst),
        .user_rst(user_rst),
        .link_ready(link_ready),
        .seq_fail(seq_fail),
        .retry_cnt(retry_cnt),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_st(input string tag, input int st, input int cr, input int ur,
                          input int lr, input int sf, input int rc);
        chk($sformatf("%s.seq_state", tag), 32'(seq_state), st);
        chk($sformatf("%s.core_rst", tag), 32'(core_rst), cr);
        chk($sformatf("%s.user_rst", tag), 32'(user_rst), ur);
        chk($sformatf("%s.link_ready", tag), 32'(link_ready), lr);
        chk($sformatf("%s.seq_fail", tag), 32'(seq_fail), sf);
        chk($sformatf("%s.retry_cnt", tag), 32'(retry_cnt), rc);
    endtask

    initial begin
        step(2);
        exp_st("reset", 0, 1, 1, 0, 0, 0);
        rst = 1'b0;
        step(3);
        exp_st("hold_idle", 0, 1, 1, 0, 0, 0);

        // Nominal bring-up: t0 is the edge just passed
        pcie_rstn = 1'b1;
        step(9);
        chk("t1_hold_e9", 32'(seq_state), 0);
        step(1);
        chk("t1_waitpll_e10", 32'(seq_state), 1);
        step(4);
        exp_st("t1_release_e14", 2, 1, 1, 0, 0, 0);
        step(1);
        exp_st("t1_waitlink_e15", 3, 0, 1, 0, 0, 0);
        step(5);
        link_up = 1'b1;
        step(2);
        exp_st("t1_linksync_e22", 3, 0, 1, 0, 0, 0);
        step(1);
        exp_st("t1_up_e23", 5, 0, 0, 1, 0, 0);

        // Link drop while UP
        step(3);
        chk("t4_up_stable", 32'(seq_state), 5);
        link_up = 1'b0;
        step(2);
        chk("t4_drop_sync", 32'(seq_state), 5);
        step(1);
`ifdef PCIE_SEQ_RETRAIN_EN
        exp_st("t4_retrain", 3, 0, 1, 0, 0, 0);
`else
        exp_st("t4_retry", 4, 1, 1, 0, 0, 1);
`endif
        pcie_rstn = 1'b0;
        step(3);
        exp_st("t4_perst_hold", 0, 1, 1, 0, 0, 0);

        // One-cycle PERST# glitch at debounce count 5 restarts the debounce
        pcie_rstn = 1'b1;
        step(7);
        pcie_rstn = 1'b0;
        step(1);
        pcie_rstn = 1'b1;
        step(2);
        chk("t2_glitch_e10", 32'(seq_state), 0);
        step(7);
        chk("t2_hold_e17", 32'(seq_state), 0);
        step(1);
        chk("t2_waitpll_e18", 32'(seq_state), 1);
        step(4);
        exp_st("t2_release_e22", 2, 1, 1, 0, 0, 0);
        step(1);
        exp_st("t2_waitlink_e23", 3, 0, 1, 0, 0, 0);

        // PERST# low in the same cycle link_up rises: HOLD wins
        step(2);
        link_up   = 1'b1;
        pcie_rstn = 1'b0;
        step(2);
        exp_st("t5_sync", 3, 0, 1, 0, 0, 0);
        step(1);
        exp_st("t5_hold", 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("t5_no_ready_%0d", i), 32'(link_ready), 0);
        end

        // Async rst in UP
        pcie_rstn = 1'b1;
        step(15);
        exp_st("t6_waitlink", 3, 0, 1, 0, 0, 0);
        step(1);
        exp_st("t6_up", 5, 0, 0, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        exp_st("t6_async_rst", 0, 1, 1, 0, 0, 0);
        step(1);
        rst       = 1'b0;
        link_up   = 1'b0;
        pcie_rstn = 1'b0;
        step(4);
        exp_st("t3_start_hold", 0, 1, 1, 0, 0, 0);

        // Link never comes up: two retries then FAIL
        pcie_rstn = 1'b1;
        step(46);
        chk("t3_waitlink_e46", 32'(seq_state), 3);
        step(1);
        exp_st("t3_retry1_e47", 4, 1, 1, 0, 0, 1);
        step(4);
        exp_st("t3_waitpll_e51", 1, 1, 1, 0, 0, 1);
        step(5);
        exp_st("t3_waitlink_e56", 3, 0, 1, 0, 0, 1);
        step(32);
        exp_st("t3_retry2_e88", 4, 1, 1, 0, 0, 2);
        step(3);
        chk("t3_retry2_e91", 32'(seq_state), 4);
        step(1);
        exp_st("t3_fail_e92", 6, 1, 1, 0, 1, 2);
        step(8);
        exp_st("t3_fail_sticky", 6, 1, 1, 0, 1, 2);
        pcie_rstn = 1'b0;
        step(2);
        exp_st("t3_fail_sync", 6, 1, 1, 0, 1, 2);
        step(1);
        exp_st("t3_clean_hold", 0, 1, 1, 0, 0, 0);
        pcie_rstn = 1'b1;
        step(3);
        exp_st("t3_rehold", 0, 1, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
